// File: rtl/fp_pkg.sv
// Shared widths, constants, operand layout and FSM states for the binary32 adder.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 2 * BIAS + 1;
  localparam int unsigned SIG_W   = FRAC_W + 1;
  // Significand plus guard, round and sticky bits.
  localparam int unsigned EXT_W   = SIG_W + 3;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StDone
  } state_t;

  function automatic logic is_nan(fp32_t x);
    return (x.exp == '1) && (x.frac != '0);
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x.exp == '1) && (x.frac == '0);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the 27-bit extended significand; all-zero input yields 27.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [EXT_W-1:0] i_value,
  output logic [4:0]       o_count
);

  always_comb begin
    o_count = 5'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (i_value[i]) o_count = 5'(int'(EXT_W) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_adder.sv
// Multi-cycle binary32 adder, round-to-nearest-even, one operation in flight.
// FP_ADDER_SUBNORMAL_EN enables gradual underflow; otherwise subnormals flush to zero.
module fp_adder
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        valid,
  output logic [31:0] result,
  output logic        done
);

  localparam logic [9:0] EXP_TOP = 10'(EXP_MAX);

  state_t           r_state, w_state_next;
  fp32_t            r_op_a, r_op_b;
  logic             r_sign, r_sub, r_special, r_done;
  logic [9:0]       r_exp;
  logic [EXT_W-1:0] r_mant_a, r_mant_b, r_norm;
  logic [EXT_W:0]   r_sum;
  logic [31:0]      r_special_val, r_rounded, r_result;

  logic [9:0]       w_ea, w_eb, w_e_big, w_e_small, w_diff, w_shamt, w_rexp;
  logic [SIG_W-1:0] w_ma, w_mb, w_m_big, w_m_small, w_rmant;
  logic [EXT_W-1:0] w_small_ext, w_aligned;
  logic [SIG_W:0]   w_rnd;
  logic [31:0]      w_special_val, w_res;
  logic [4:0]       w_lzc;
  logic             w_a_big, w_special, w_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (valid) w_state_next = StAlign;
      StAlign: w_state_next = StAdd;
      StAdd:   w_state_next = StNorm;
      StNorm:  w_state_next = StRound;
      StRound: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Zero/subnormal exponents map to 1 so alignment treats them like the smallest normal.
  always_comb begin
    w_ea = (r_op_a.exp == '0) ? 10'd1 : {2'b00, r_op_a.exp};
    w_eb = (r_op_b.exp == '0) ? 10'd1 : {2'b00, r_op_b.exp};
`ifdef FP_ADDER_SUBNORMAL_EN
    w_ma = {r_op_a.exp != '0, r_op_a.frac};
    w_mb = {r_op_b.exp != '0, r_op_b.frac};
`else
    w_ma = (r_op_a.exp == '0) ? '0 : {1'b1, r_op_a.frac};
    w_mb = (r_op_b.exp == '0) ? '0 : {1'b1, r_op_b.frac};
`endif
    w_a_big     = {w_ea, w_ma} >= {w_eb, w_mb};
    w_e_big     = w_a_big ? w_ea : w_eb;
    w_e_small   = w_a_big ? w_eb : w_ea;
    w_m_big     = w_a_big ? w_ma : w_mb;
    w_m_small   = w_a_big ? w_mb : w_ma;
    w_diff      = w_e_big - w_e_small;
    w_small_ext = {w_m_small, 3'b000};
    if (w_diff >= 10'd26) begin
      w_aligned = {{(EXT_W-1){1'b0}}, |w_m_small};
    end else begin
      w_aligned = (w_small_ext >> w_diff) |
                  {{(EXT_W-1){1'b0}}, |(w_small_ext & ~({EXT_W{1'b1}} << w_diff))};
    end

    w_special     = 1'b1;
    w_special_val = QNAN;
    if (is_nan(r_op_a) || is_nan(r_op_b)) begin
      w_special_val = QNAN;
    end else if (is_inf(r_op_a) && is_inf(r_op_b) && (r_op_a.sign != r_op_b.sign)) begin
      w_special_val = QNAN;
    end else if (is_inf(r_op_a)) begin
      w_special_val = r_op_a;
    end else if (is_inf(r_op_b)) begin
      w_special_val = r_op_b;
    end else begin
      w_special = 1'b0;
    end
  end

  fp_lzc u_lzc (
    .i_value (r_sum[EXT_W-1:0]),
    .o_count (w_lzc)
  );

  // Left shift stops once the exponent reaches 1; what remains is subnormal (or flushed).
  always_comb begin
    w_shamt = (r_exp > {5'b00000, w_lzc}) ? {5'b00000, w_lzc} : r_exp - 10'd1;
  end

  always_comb begin
    w_up  = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    w_rnd = {1'b0, r_norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, w_up};
    if (w_rnd[SIG_W]) begin
      w_rmant = w_rnd[SIG_W:1];
      w_rexp  = r_exp + 10'd1;
    end else begin
      w_rmant = w_rnd[SIG_W-1:0];
      w_rexp  = r_exp;
    end
    if (r_special) begin
      w_res = r_special_val;
    end else if (w_rexp >= EXP_TOP) begin
      w_res = POS_INF | {r_sign, 31'b0};
    end else if (!w_rmant[SIG_W-1]) begin
`ifdef FP_ADDER_SUBNORMAL_EN
      w_res = {r_sign, 8'h00, w_rmant[FRAC_W-1:0]};
`else
      w_res = {r_sign, 31'b0};
`endif
    end else begin
      w_res = {r_sign, w_rexp[7:0], w_rmant[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_sign        <= 1'b0;
      r_sub         <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_exp         <= '0;
      r_mant_a      <= '0;
      r_mant_b      <= '0;
      r_sum         <= '0;
      r_norm        <= '0;
      r_rounded     <= '0;
      r_result      <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (r_state == StDone);
      case (r_state)
        StIdle: begin
          if (valid) begin
            r_op_a <= op1;
            r_op_b <= op2;
          end
        end
        StAlign: begin
          r_sign        <= w_a_big ? r_op_a.sign : r_op_b.sign;
          r_sub         <= r_op_a.sign ^ r_op_b.sign;
          r_exp         <= w_e_big;
          r_mant_a      <= {w_m_big, 3'b000};
          r_mant_b      <= w_aligned;
          r_special     <= w_special;
          r_special_val <= w_special_val;
        end
        StAdd: begin
          r_sum <= r_sub ? {1'b0, r_mant_a} - {1'b0, r_mant_b}
                         : {1'b0, r_mant_a} + {1'b0, r_mant_b};
          // Exact cancellation always yields +0.
          if (r_sub && (r_mant_a == r_mant_b)) r_sign <= 1'b0;
        end
        StNorm: begin
          if (r_sum[EXT_W]) begin
            r_norm <= {r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + 10'd1;
          end else begin
            r_norm <= r_sum[EXT_W-1:0] << w_shamt;
            r_exp  <= r_exp - w_shamt;
          end
        end
        StRound: r_rounded <= w_res;
        StDone:  r_result  <= r_rounded;
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_fp_adder.sv
// Directed scoreboard bench for fp_adder; expected sums are queued at issue and popped on done.
module tb_fp_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] op1, op2, result;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

  fp_adder dut (
    .clk    (clk),
    .reset  (reset),
    .op1    (op1),
    .op2    (op2),
    .valid  (valid),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one strobe; operands are scrambled right after capture.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                       input bit push);
    @(negedge clk);
    op1   = a;
    op2   = b;
    valid = 1'b1;
    if (push) sb_q.push_back(expv);
    @(posedge clk);
    #1;
    valid = 1'b0;
    op1   = $urandom();
    op2   = $urandom();
  endtask

  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      seen = done;
    end
  endtask

  task automatic finish_op(input string tag);
    int          lat;
    bit          seen;
    logic [31:0] expv;
    wait_done(lat, seen);
    check({tag, ":done"}, 32'(seen), 32'd1);
    check({tag, ":lat"}, 32'(lat), 32'd5);
    expv = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEADBEEF;
    check({tag, ":res"}, result, expv);
    @(posedge clk);
    #1;
    check({tag, ":pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                     input string tag);
    issue(a, b, expv, 1'b1);
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    int pulses;
    logic [31:0] expv;

    reset = 1'b1;
    valid = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:result", result, 32'h0);
    check("reset:done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(32'h40200000, 32'h40400000, 32'h40B00000, "add_2p5_3p0");
    run(32'h40200000, 32'hC0400000, 32'hBF000000, "sub_2p5_3p0");
    run(32'hC0200000, 32'hC0400000, 32'hC0B00000, "add_neg");
    run(32'h40200000, 32'h7F800000, 32'h7F800000, "fin_plus_inf");
    run(32'hC0000000, 32'hFF800000, 32'hFF800000, "fin_plus_ninf");
    run(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    run(32'h7F800000, 32'h7F800000, 32'h7F800000, "inf_plus_inf");
    run(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_a");
    run(32'h3F800000, 32'hFF800001, 32'h7FC00000, "nan_b");
    run(32'h3F800000, 32'hBF800000, 32'h00000000, "cancel");
    run(32'h80000000, 32'h80000000, 32'h80000000, "negzero");
    run(32'h3FC00000, 32'h00000000, 32'h3FC00000, "x_plus_0");
    run(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even");
    run(32'h3F800001, 32'h33800000, 32'h3F800002, "tie_odd");
    run(32'h3F800000, 32'h33C00000, 32'h3F800001, "round_up");
    run(32'h3F800001, 32'hBF800000, 32'h34000000, "lzc_shift");
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
`ifdef FP_ADDER_SUBNORMAL_EN
    run(32'h00400000, 32'h00400000, 32'h00800000, "sub_to_norm");
    run(32'h00000001, 32'h00000001, 32'h00000002, "sub_tiny");
`else
    run(32'h00400000, 32'h00400000, 32'h00000000, "sub_to_norm");
    run(32'h00000001, 32'h00000001, 32'h00000000, "sub_tiny");
`endif
    run(32'h00400000, 32'h3F800000, 32'h3F800000, "sub_plus_one");

    // Strobes during ALIGN/ADD/NORM must be ignored.
    issue(32'h40200000, 32'h40400000, 32'h40B00000, 1'b1);
    valid = 1'b1;
    op1   = 32'h3F800000;
    op2   = 32'h3F800000;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) valid = 1'b0;
      seen = done;
    end
    check("busy:done", 32'(seen), 32'd1);
    check("busy:lat", 32'(lat), 32'd5);
    expv = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEADBEEF;
    check("busy:res", result, expv);
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("busy:extra_done", 32'(pulses), 32'd0);

    // Reset while the operation sits in ADD: aborted, no pulse, result cleared.
    issue(32'h40200000, 32'h40400000, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid:result", result, 32'h0);
    check("rst_mid:done", 32'(done), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("rst_mid:no_done", 32'(pulses), 32'd0);
    run(32'h3F800000, 32'h3F800000, 32'h40000000, "after_reset");

    check("sb:empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
